// File: rtl/example_sequencer_pkg.sv
// Shared fixed-point type and helpers for the training datapath, plus the
// sequencer state encoding (also used by the bench for visibility).
package example_sequencer_pkg;

  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  function automatic sfp int_to_sfp(input int v);
    return sfp'(v <<< SFP_FRAC);
  endfunction

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_PRESENT,
    SEQ_WAIT_RES,
    SEQ_ADVANCE,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/example_sequencer.sv
// Walks the example store epoch after epoch, presenting each example to the
// perceptron and stopping on the first error-free epoch or at max_epochs.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | store output for current index captured into out_values
// PRESENT  | out_valid high until out_ready
// WAIT_RES | waiting for the perceptron result of the accepted example
// ADVANCE  | step index, or wrap the epoch and decide converged/limit
// DONE     | training finished, done/converged held until start or rst
module example_sequencer
  import example_sequencer_pkg::*;
#(
  parameter int inputs         = 2,
  parameter int total_examples = 4,
  parameter int max_epochs     = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [31:0]       example,
  input  sfp [inputs-1:0]   data_values,
  input  sfp                data_expected,
  output logic              out_valid,
  input  logic              out_ready,
  output sfp [inputs-1:0]   out_values,
  output sfp                out_expected,
  output logic              out_last,
  input  logic              result_valid,
  input  logic              result_error,
  output logic [31:0]       epoch,
  output logic              busy,
  output logic              done,
  output logic              converged
);

  localparam logic [31:0] LAST_EX = 32'(total_examples - 1);
  localparam logic [31:0] MAX_EP  = 32'(max_epochs);

  seq_state_t  state, state_next;
  logic        err_flag;
  logic        last_ex;
  logic [31:0] epoch_inc;

  assign last_ex   = (example == LAST_EX);
  assign epoch_inc = epoch + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= SEQ_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE, SEQ_DONE: if (start) state_next = SEQ_FETCH;
      SEQ_FETCH:          state_next = SEQ_PRESENT;
      SEQ_PRESENT:        if (out_ready) state_next = SEQ_WAIT_RES;
      SEQ_WAIT_RES:       if (result_valid) state_next = SEQ_ADVANCE;
      SEQ_ADVANCE: begin
        if (!last_ex)                state_next = SEQ_FETCH;
        else if (!err_flag)          state_next = SEQ_DONE;
        else if (epoch_inc == MAX_EP) state_next = SEQ_DONE;
        else                         state_next = SEQ_FETCH;
      end
      default:            state_next = SEQ_IDLE;
    endcase
  end

  assign out_valid = (state == SEQ_PRESENT);
  assign busy      = (state != SEQ_IDLE) && (state != SEQ_DONE);
  assign done      = (state == SEQ_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      example      <= '0;
      epoch        <= '0;
      err_flag     <= 1'b0;
      converged    <= 1'b0;
      out_last     <= 1'b0;
      out_values   <= '0;
      out_expected <= '0;
    end else begin
      case (state)
        SEQ_IDLE, SEQ_DONE: begin
          if (start) begin
            example   <= '0;
            epoch     <= '0;
            err_flag  <= 1'b0;
            converged <= 1'b0;
          end
        end
        SEQ_FETCH: begin
          out_values   <= data_values;
          out_expected <= data_expected;
          out_last     <= last_ex;
        end
        SEQ_WAIT_RES: begin
          if (result_valid) err_flag <= err_flag | result_error;
        end
        SEQ_ADVANCE: begin
          if (!last_ex) begin
            example <= example + 32'd1;
          end else begin
            example <= '0;
            epoch   <= epoch_inc;
            // A failed epoch that still has budget starts the next one clean.
            if (!err_flag)                converged <= 1'b1;
            else if (epoch_inc != MAX_EP) err_flag  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_example_sequencer.sv
// Bench for example_sequencer: behavioural epoch/example walk with random
// stalls, result delays and error patterns, plus reset and noise scenarios.
module tb_example_sequencer;
  import example_sequencer_pkg::*;

  localparam int INPUTS = 2;
  localparam int TOTAL  = 4;
  localparam int MAX_EP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic result_valid = 1'b0;
  logic result_error = 1'b0;
  logic [31:0] example, epoch;
  sfp [INPUTS-1:0] data_values, out_values;
  sfp data_expected, out_expected;
  logic out_valid, out_last, busy, done, converged;

  sfp [INPUTS-1:0] store_vals [TOTAL];
  sfp              store_exp  [TOTAL];
  bit              err_map    [MAX_EP][TOTAL];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural example store: combinational lookup on the index.
  assign data_values   = (example < 32'(TOTAL)) ? store_vals[example[1:0]] : '0;
  assign data_expected = (example < 32'(TOTAL)) ? store_exp[example[1:0]]  : '0;

  example_sequencer #(
    .inputs(INPUTS), .total_examples(TOTAL), .max_epochs(MAX_EP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .example(example),
    .data_values(data_values), .data_expected(data_expected),
    .out_valid(out_valid), .out_ready(out_ready), .out_values(out_values),
    .out_expected(out_expected), .out_last(out_last),
    .result_valid(result_valid), .result_error(result_error),
    .epoch(epoch), .busy(busy), .done(done), .converged(converged)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (example !== 0 || epoch !== 0 || out_valid !== 0 || out_last !== 0 ||
        busy !== 0 || done !== 0 || converged !== 0 || out_values !== '0 || out_expected !== '0) begin
      errors++;
      $display("FAIL reset: ex=%0d ep=%0d v=%b l=%b busy=%b done=%b conv=%b vals=%h exp=%h, required all zero",
               example, epoch, out_valid, out_last, busy, done, converged, out_values, out_expected);
    end
  endtask

  // Runs one training session and checks it against an epoch/example walk.
  // stall_first >= 0 forces that many not-ready cycles on the first example.
  // abort_ep/abort_ex >= 0 assert rst while waiting for that example's result.
  task automatic run_train(input string name, input bit noise, input int stall_first,
                           input int abort_ep, input int abort_ex);
    int  exp_epoch, lat, n, stall, dly;
    bit  exp_conv, stop, ep_err, first;
    sfp [INPUTS-1:0] hold_vals;
    sfp  hold_exp;
    logic hold_last;
    exp_epoch = 0;
    exp_conv  = 0;
    stop      = 0;
    first     = 1;
    lat       = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1 || done !== 0 || converged !== 0 || out_valid !== 0) begin
      errors++;
      $display("FAIL %s start: busy=%b done=%b conv=%b v=%b, required 1 0 0 0", name, busy, done, converged, out_valid);
    end
    for (int e = 0; e < MAX_EP && !stop; e++) begin
      ep_err = 0;
      for (int x = 0; x < TOTAL; x++) begin
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
          tick();
          n++;
        end
        checks++;
        if (out_valid !== 1'b1 || n != lat) begin
          errors++;
          $display("FAIL %s latency e%0d x%0d: valid=%b after %0d cycles, required 1 after %0d", name, e, x, out_valid, n, lat);
        end
        checks++;
        if (example !== 32'(x) || out_values !== store_vals[x] || out_expected !== store_exp[x] ||
            out_last !== (x == TOTAL - 1) || epoch !== 32'(e)) begin
          errors++;
          $display("FAIL %s payload e%0d x%0d: ex=%0d ep=%0d vals=%h exp=%h last=%b, required ex=%0d ep=%0d vals=%h exp=%h last=%b",
                   name, e, x, example, epoch, out_values, out_expected, out_last,
                   x, e, store_vals[x], store_exp[x], (x == TOTAL - 1));
        end
        hold_vals = out_values;
        hold_exp  = out_expected;
        hold_last = out_last;
        stall = (first && stall_first >= 0) ? stall_first : int'($urandom_range(noise ? 1 : 0, 3));
        first = 0;
        for (int s = 0; s < stall; s++) begin
          if (noise) begin
            start        = 1'b1;
            result_valid = 1'b1;
            result_error = 1'b1;
          end
          tick();
          start        = 1'b0;
          result_valid = 1'b0;
          result_error = 1'b0;
          checks++;
          if (out_valid !== 1 || out_values !== hold_vals || out_expected !== hold_exp ||
              out_last !== hold_last || example !== 32'(x)) begin
            errors++;
            $display("FAIL %s stall e%0d x%0d s%0d: v=%b vals=%h exp=%h last=%b ex=%0d, required 1 %h %h %b %0d",
                     name, e, x, s, out_valid, out_values, out_expected, out_last, example,
                     hold_vals, hold_exp, hold_last, x);
          end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 0 || busy !== 1) begin
          errors++;
          $display("FAIL %s accept e%0d x%0d: v=%b busy=%b, required 0 1", name, e, x, out_valid, busy);
        end
        if (e == abort_ep && x == abort_ex) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          checks++;
          if (example !== 0 || epoch !== 0 || out_valid !== 0 || out_last !== 0 ||
              busy !== 0 || done !== 0 || converged !== 0 || out_values !== '0 || out_expected !== '0) begin
            errors++;
            $display("FAIL %s abort: ex=%0d ep=%0d v=%b l=%b busy=%b done=%b conv=%b vals=%h exp=%h, required all zero",
                     name, example, epoch, out_valid, out_last, busy, done, converged, out_values, out_expected);
          end
          return;
        end
        dly = int'($urandom_range(0, 2));
        for (int d = 0; d < dly; d++) begin
          if (noise) start = 1'b1;
          tick();
          start = 1'b0;
        end
        result_valid = 1'b1;
        result_error = err_map[e][x];
        tick();
        result_valid = 1'b0;
        result_error = 1'b0;
        ep_err |= err_map[e][x];
        lat = 2;
      end
      exp_epoch = e + 1;
      if (!ep_err) begin
        stop = 1;
        exp_conv = 1;
      end else if (e + 1 == MAX_EP) begin
        stop = 1;
        exp_conv = 0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (done !== 1 || busy !== 0 || converged !== exp_conv || epoch !== 32'(exp_epoch) ||
          example !== 0 || out_valid !== 0) begin
        errors++;
        $display("FAIL %s finish c%0d: done=%b busy=%b conv=%b ep=%0d ex=%0d v=%b, required 1 0 %b %0d 0 0",
                 name, k, done, busy, converged, epoch, example, out_valid, exp_conv, exp_epoch);
      end
    end
  endtask

  task automatic fill_map(input int mode);
    for (int e = 0; e < MAX_EP; e++)
      for (int x = 0; x < TOTAL; x++)
        case (mode)
          0: err_map[e][x] = 1'b0;
          1: err_map[e][x] = 1'b1;
          2: err_map[e][x] = (e == 0 && x == 2);
          default: err_map[e][x] = ($urandom_range(0, 3) == 0);
        endcase
  endtask

  task automatic test_converge();
    fill_map(0);
    run_train("converge", 1'b0, -1, -1, -1);
  endtask

  task automatic test_no_converge();
    fill_map(1);
    run_train("no_converge", 1'b0, -1, -1, -1);
  endtask

  task automatic test_late_converge();
    fill_map(2);
    run_train("late_converge", 1'b0, -1, -1, -1);
  endtask

  task automatic test_backpressure();
    fill_map(3);
    run_train("backpressure", 1'b0, 5, -1, -1);
  endtask

  task automatic test_abort_restart();
    fill_map(1);
    run_train("abort", 1'b0, -1, 1, 2);
    result_valid = 1'b1;
    result_error = 1'b1;
    tick();
    result_valid = 1'b0;
    result_error = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 0 || done !== 0 || out_valid !== 0 || example !== 0 || epoch !== 0) begin
      errors++;
      $display("FAIL stray_result: busy=%b done=%b v=%b ex=%0d ep=%0d, required 0 0 0 0 0",
               busy, done, out_valid, example, epoch);
    end
    fill_map(0);
    run_train("restart", 1'b0, -1, -1, -1);
  endtask

  task automatic test_ignored();
    fill_map(2);
    run_train("ignored", 1'b1, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fill_map(3);
      run_train("random", 1'b0, -1, -1, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < TOTAL; i++) begin
      store_vals[i][0] = int_to_sfp(i >> 1);
      store_vals[i][1] = int_to_sfp(i & 1);
      store_exp[i]     = int_to_sfp((i == TOTAL - 1) ? 1 : 0);
    end
    test_reset();
    test_converge();
    test_no_converge();
    test_late_converge();
    test_backpressure();
    test_abort_restart();
    test_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
